// File: rtl/fpu_pkg.sv
// Shared types for the FPU arbiter: FPU status codes, number format, arbiter states.
package fpu_pkg;

    localparam int EXP_W  = 10;
    localparam int MANT_W = 21;
    localparam int BIAS   = 511;

    typedef enum logic [3:0] {
        EXACT     = 4'h0,
        INEXACT   = 4'h1,
        UNDERFLOW = 4'h2,
        OVERFLOW  = 4'h4
    } status_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

endpackage

// File: rtl/fpu_arbiter_if.sv
// Requester, response and FPU-side signals of the FPU arbiter.
// slave: the arbiter's view. master: the requesters/FPU environment's view.
interface fpu_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    import fpu_pkg::*;

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0][31:0] req_op_a;
    logic [NUM_REQ-1:0][31:0] req_op_b;

    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [31:0]              rsp_data;
    status_t                  rsp_status;
    logic                     rsp_timeout;

    logic                     fpu_start;
    logic [31:0]              fpu_op_a;
    logic [31:0]              fpu_op_b;
    logic                     fpu_done;
    logic [31:0]              fpu_result;
    status_t                  fpu_status;

    modport slave (
        input  req_valid, req_op_a, req_op_b, rsp_ready,
               fpu_done, fpu_result, fpu_status,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_status, rsp_timeout,
               fpu_start, fpu_op_a, fpu_op_b
    );

    modport master (
        output req_valid, req_op_a, req_op_b, rsp_ready,
               fpu_done, fpu_result, fpu_status,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_status, rsp_timeout,
               fpu_start, fpu_op_a, fpu_op_b
    );

endinterface

// File: rtl/fpu_arbiter_rr_picker.sv
// Rotate-priority picker: first set bit of valid at or after ptr, wrapping.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    id,
    output logic               any
);

    int idx;

    // Walk the requesters in rotated order; the first valid one wins.
    always_comb begin
        grant = '0;
        id    = '0;
        any   = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!any && valid[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                id         = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one multi-cycle FPU adder between NUM_REQ requesters.
// One operation in flight: grant -> start pulse -> wait for done -> tagged response.
// Optional watchdog on the FPU wait: define FPU_ARB_WDT_EN.
module fpu_arbiter
    import fpu_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = $clog2(NUM_REQ),
    parameter int WDT_CYCLES = 64
) (
    input  logic          clock_100Khz,
    input  logic          reset,
    fpu_arbiter_if.slave  bus,
    output logic          busy
);

    arb_state_t         state, state_nxt;
    logic [ID_W-1:0]    rr_ptr, win_id, pick_id;
    logic [NUM_REQ-1:0] pick_gnt;
    logic               pick_any;
    logic [31:0]        op_a, op_b, rsp_data;
    status_t            rsp_status;
    logic               rsp_timeout;
    logic               wdt_expire;

    rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
        .valid (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (pick_gnt),
        .id    (pick_id),
        .any   (pick_any)
    );

`ifdef FPU_ARB_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);
    logic [WDT_W-1:0] wdt_cnt;

    // Count WAIT cycles; cleared during ISSUE so it reads 0 on the first WAIT cycle.
    always_ff @(posedge clock_100Khz or posedge reset) begin
        if (reset)               wdt_cnt <= '0;
        else if (state == ISSUE) wdt_cnt <= '0;
        else if (state == WAIT)  wdt_cnt <= wdt_cnt + 1'b1;
    end

    // Fires on the WDT_CYCLES-th WAIT cycle; fpu_done in that cycle still wins.
    assign wdt_expire = (state == WAIT) && (wdt_cnt == WDT_W'(WDT_CYCLES - 1));
`else
    assign wdt_expire = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock_100Khz or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and handshake outputs; req_ready is masked while reset is held.
    always_comb begin
        state_nxt     = state;
        bus.req_ready = '0;
        bus.fpu_start = 1'b0;
        bus.rsp_valid = 1'b0;
        busy          = (state != IDLE);
        case (state)
            IDLE: begin
                if (!reset) bus.req_ready = pick_gnt;
                if (pick_any) state_nxt = ISSUE;
            end
            ISSUE: begin
                bus.fpu_start = 1'b1;
                state_nxt     = WAIT;
            end
            WAIT: begin
                if (bus.fpu_done || wdt_expire) state_nxt = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch at grant, response capture, and pointer advance after handshake.
    always_ff @(posedge clock_100Khz or posedge reset) begin
        if (reset) begin
            rr_ptr      <= '0;
            win_id      <= '0;
            op_a        <= '0;
            op_b        <= '0;
            rsp_data    <= '0;
            rsp_status  <= EXACT;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: if (pick_any) begin
                    win_id <= pick_id;
                    op_a   <= bus.req_op_a[pick_id];
                    op_b   <= bus.req_op_b[pick_id];
                end
                WAIT: if (bus.fpu_done) begin
                    rsp_data    <= bus.fpu_result;
                    rsp_status  <= bus.fpu_status;
                    rsp_timeout <= 1'b0;
                end else if (wdt_expire) begin
                    rsp_data    <= 32'h0;
                    rsp_status  <= INEXACT;
                    rsp_timeout <= 1'b1;
                end
                RESP: if (bus.rsp_ready) begin
                    rr_ptr <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.rsp_id      = win_id;
    assign bus.rsp_data    = rsp_data;
    assign bus.rsp_status  = rsp_status;
    assign bus.rsp_timeout = rsp_timeout;
    assign bus.fpu_op_a    = op_a;
    assign bus.fpu_op_b    = op_b;

endmodule

// File: doc/fpu_arbiter.md
Name: fpu_arbiter

Overview:
- Shares one multi-cycle FPU adder (1-bit sign, 10-bit exponent, 21-bit mantissa) between NUM_REQ requesters.
- Uses round-robin arbitration, a valid/ready request channel per requester, and one shared response channel tagged with the requester id.
- Sequences the FPU with a start/done handshake and holds its operands stable for the whole operation.
- Sits between the requesters and the FPU.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of requester id.
- WDT_CYCLES, 64, watchdog limit in cycles (used only with the optional feature).

Ports:
- clock_100Khz  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  one-hot grant/accept, pulsed for one cycle.
- req_op_a  input  NUM_REQ x 32  operand A per requester.
- req_op_b  input  NUM_REQ x 32  operand B per requester.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accepted by the addressed requester.
- rsp_id  output  ID_W  requester the response belongs to.
- rsp_data  output  32  FPU result.
- rsp_status  output  4  status_t from the FPU.
- rsp_timeout  output  1  watchdog fired; rsp_data is invalid.
- fpu_start  output  1  one-cycle start pulse to the FPU.
- fpu_op_a  output  32  registered operand A to the FPU.
- fpu_op_b  output  32  registered operand B to the FPU.
- fpu_done  input  1  FPU result valid (single-cycle pulse).
- fpu_result  input  32  FPU data out.
- fpu_status  input  4  FPU status_t.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (asynchronous, active-high, any state):
  - state=IDLE, rr_ptr=0.
  - All outputs are 0, with rsp_status=EXACT.
  - Any in-flight FPU operation is abandoned; a later fpu_done is ignored because state is IDLE.
- IDLE:
  - Search req_valid starting at rr_ptr, wrapping modulo NUM_REQ. The first set bit wins.
  - Winner: drive req_ready[winner]=1 for this cycle only, latch its operands into fpu_op_a/fpu_op_b, store winner id, go to ISSUE.
  - No request: stay in IDLE with req_ready=0.
- ISSUE: fpu_start=1 for exactly one cycle, then go to WAIT. fpu_done is ignored in ISSUE; the FPU minimum latency is 2 cycles.
- WAIT:
  - On fpu_done: capture fpu_result into rsp_data and fpu_status into rsp_status, set rsp_timeout=0, go to RESP.
  - fpu_op_a/fpu_op_b stay constant throughout WAIT.
- RESP:
  - rsp_valid=1. rsp_id/rsp_data/rsp_status/rsp_timeout are held stable until rsp_ready=1.
  - On rsp_valid&&rsp_ready: rsp_valid drops next cycle, rr_ptr = (winner+1) mod NUM_REQ, go to IDLE.
- Throughput: no new grant while busy; one operation in flight.
- Latency: grant cycle G, fpu_start at G+1, fpu_done at D, rsp_valid at D+1. A back-to-back grant is possible in the cycle after the response handshake.
- Protocol rules:
  - A requester holds req_valid and its operands until req_ready.
  - Deasserting req_valid before grant is legal; that requester is simply skipped.
  - rsp_ready asserted while rsp_valid=0 has no effect.
- Fairness: with all requesters asserting continuously, grants rotate 0,1,2,3,0,... No requester waits more than NUM_REQ-1 operations.
- rr_ptr wraps from NUM_REQ-1 to 0.

Optional Feature:
- Macro FPU_ARB_WDT_EN.
- Defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches WDT_CYCLES with no fpu_done, go to RESP with rsp_timeout=1, rsp_data=32'h0, rsp_status=INEXACT.
  - fpu_done arriving in the same cycle as expiry wins, so the response is normal.
- Undefined: no counter; WAIT persists until fpu_done; rsp_timeout is tied to 0.

Decomposition:
- Package fpu_pkg holds:
  - status_t (OVERFLOW, UNDERFLOW, EXACT, INEXACT; logic[3:0]).
  - EXP_W=10, MANT_W=21, BIAS=511.
  - arbiter state enum arb_state_t (IDLE, ISSUE, WAIT, RESP).
- One sub-module, rr_picker: combinational rotate-priority select from (req_valid, rr_ptr) giving a one-hot grant and an id.

Test Plan:
- Single request: req 2, op_a=32'h3FE00000 (1.0), op_b=32'h3FE00000, FPU model latency 7 returns 32'h40000000/EXACT. Expect req_ready[2] at G, fpu_start at G+1, rsp_valid at G+8 with rsp_id=2, rsp_data=32'h40000000.
- All four requesters valid continuously for 8 operations. Expect grant order 0,1,2,3,0,1,2,3, one fpu_start per operation, no overlap.
- Response backpressure: rsp_ready held 0 for 5 cycles. Expect rsp_valid/rsp_data stable, no new req_ready until the handshake; grant occurs the cycle after it.
- Reset asserted during WAIT, then fpu_done pulses 2 cycles later. Expect all outputs 0 immediately (asynchronous), no rsp_valid, rr_ptr=0 on the next grant.
- Requester 1 drops req_valid before its turn while 0 and 3 are valid with rr_ptr=1. Expect grant to 3, then 0.
- With FPU_ARB_WDT_EN, WDT_CYCLES=64, the FPU model never asserts done. Expect rsp_valid 64 cycles after entering WAIT with rsp_timeout=1, rsp_data=0.
